// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic stage: the main register feeds downstream, and the skid register absorbs one beat on stall.
// o_valid, o_ready and o_occupancy decode from the state register only, so no handshake path is combinational.
module pipe_skid_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_main_next;
  logic [DATA_WIDTH-1:0] w_skid_next;
  logic                  w_in_fire;
  logic                  w_out_fire;

  assign o_valid     = (r_state != ST_EMPTY);
  assign o_ready     = (r_state != ST_FULL);
  assign o_data      = r_main;
  assign o_occupancy = r_state;  // encoding equals the beat count
  assign w_in_fire   = i_valid & o_ready;
  assign w_out_fire  = o_valid & i_ready;

  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_next = ST_BUSY;
          w_main_next  = i_data;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_next = i_data;
        end else if (w_in_fire) begin
          w_state_next = ST_FULL;
          w_skid_next  = i_data;
        end else if (w_out_fire) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_state_next = ST_BUSY;
          w_main_next  = r_skid;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
    // Register contents are left as-is on flush; only the state is cleared.
    if (i_flush) begin
      w_state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      r_main  <= w_main_next;
      r_skid  <= w_skid_next;
    end
  end

endmodule

// File: doc/pipe_skid_buffer.md
# pipe_skid_buffer

Two-entry elastic pipeline stage with a valid/ready handshake, placed directly upstream of an enable-controlled pipeline register in the core. It turns a downstream stall into a registered ready, so no combinational path runs from downstream ready back to upstream ready. It sustains one transfer per cycle and holds one extra beat when the consumer stalls. Its registered outputs feed the downstream register's write data and write enable directly.

## Interface
- DATA_WIDTH, 64, width of the payload.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_arst_n  input  1  asynchronous, active-low reset.
- i_flush  input  1  synchronous flush; discards all held beats.
- i_valid  input  1  upstream beat valid.
- i_data  input  DATA_WIDTH  upstream payload.
- o_ready  output  1  buffer can accept a beat this cycle.
- o_valid  output  1  downstream beat valid.
- o_data  output  DATA_WIDTH  downstream payload (head entry).
- i_ready  input  1  downstream accepts the beat this cycle.
- o_occupancy  output  2  number of held beats, 0..2.

## Operation
- One clock, i_clk. Reset is asynchronous and active-low (i_arst_n).
- Storage:
  - main register drives o_data.
  - skid register holds the overflow beat.
  - state register takes EMPTY, BUSY or FULL.
- Handshake events:
  - in_fire = i_valid & o_ready.
  - out_fire = o_valid & i_ready.
- Decoded outputs, taken from the state register only:
  - o_valid = (state != EMPTY).
  - o_ready = (state != FULL).
  - o_occupancy: EMPTY=0, BUSY=1, FULL=2.
- Transitions when i_flush = 0:
  - EMPTY, in_fire: move to BUSY; main <= i_data.
  - EMPTY, no in_fire: stay EMPTY.
  - BUSY, in_fire & out_fire: stay BUSY; main <= i_data.
  - BUSY, in_fire & !out_fire: move to FULL; skid <= i_data; main holds.
  - BUSY, !in_fire & out_fire: move to EMPTY.
  - BUSY, neither event: stay BUSY; main holds.
  - FULL, out_fire: move to BUSY; main <= skid. No input is accepted, since o_ready = 0.
  - FULL, no out_fire: stay FULL; both registers hold.
- Flush:
  - i_flush = 1 forces state to EMPTY on the next edge, whatever the handshakes.
  - A beat presented on the flush cycle is dropped, even when in_fire is high.
  - out_fire on the flush cycle still counts as delivered to the consumer.
  - main and skid contents are don't-care after a flush and are not cleared.
- Ordering: beats leave in strict arrival order. Beats are never duplicated and never lost, except on flush or reset.
- o_data is stable while o_valid = 1 and i_ready = 0.

## Timing
- Reset (i_arst_n low, asynchronous):
  - state = EMPTY, main = 0, skid = 0.
  - o_valid = 0, o_ready = 1, o_data = 0, o_occupancy = 0.
- Reset deassertion is assumed synchronized externally. The first in_fire can occur on the first edge after deassertion.
- Latency: a beat accepted at edge N appears on o_valid/o_data after edge N, and can be consumed in cycle N+1.
- Throughput: 1 beat per cycle while i_ready = 1.
- A stall of k cycles accepts at most 1 extra beat. o_ready drops the cycle after the buffer reaches FULL.
- o_ready returns to 1 one cycle after the out_fire that leaves FULL.
- No combinational paths:
  - i_ready to o_ready.
  - i_valid to o_valid.
  - i_data to o_data.
- Reset asserted mid-operation: outputs take their reset values immediately, without waiting for a clock edge. Held beats are lost.
- Flush and reset take precedence over all handshake activity; reset takes precedence over flush.

## Test plan
- Reset then stream, i_ready = 1: send 0x1, 0x2, 0x3 on consecutive cycles. o_data must show 0x1, 0x2, 0x3 one cycle later each, with o_valid = 1 and o_ready always 1.
- Stall fill: i_ready = 0, send 0xA then 0xB. o_occupancy goes 1 then 2, o_ready = 0, and 0xC held on i_valid is not accepted. Raise i_ready: 0xA, then 0xB, then 0xC emerge in order.
- Simultaneous in/out in BUSY: hold 0x5, then present 0x6 with i_ready = 1. Next cycle o_data = 0x6 and o_occupancy stays 1.
- Flush while FULL: with 0x11 and 0x22 held, pulse i_flush with i_valid = 1 carrying 0x33. Next cycle o_valid = 0, o_ready = 1, o_occupancy = 0, and 0x33 never appears.
- Async reset mid-stream: drop i_arst_n between edges while FULL. o_valid = 0, o_data = 0 and o_ready = 1 take effect immediately, without a clock edge.
- Random valid/ready with a scoreboard over 10,000 cycles: the output sequence equals the accepted input sequence, o_occupancy never exceeds 2, and o_data never changes while stalled.
